// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Selects ALU, aligned load or link data and counts retired instructions.
module mem_wb_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        MemValid,
   input  logic        MemRegWrite,
   input  logic [4:0]  MemWriteRegAddr,
   input  logic [1:0]  MemToReg,
   input  logic [2:0]  MemLoadType,
   input  logic [31:0] MemAluResult,
   input  logic [31:0] MemReadData,
   input  logic [31:0] MemPC,
   output logic        RegWrite,
   output logic [4:0]  WriteRegAddr,
   output logic [31:0] WriteRegData,
   output logic        WbValid,
   output logic [31:0] WbPC,
   output logic        AlignErr,
   output logic [31:0] RetireCount
);

   localparam logic [2:0] LdLb  = 3'd1;
   localparam logic [2:0] LdLbu = 3'd2;
   localparam logic [2:0] LdLh  = 3'd3;
   localparam logic [2:0] LdLhu = 3'd4;

   logic [1:0]  byteAddr;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;
   logic [31:0] nextData;
   logic        misaligned;
   logic        nextRegWrite;

   always_comb begin
      byteAddr = MemAluResult[1:0];
      loadByte = MemReadData[7:0];
      unique case (byteAddr)
         2'd0: loadByte = MemReadData[7:0];
         2'd1: loadByte = MemReadData[15:8];
         2'd2: loadByte = MemReadData[23:16];
         2'd3: loadByte = MemReadData[31:24];
      endcase
      loadHalf = byteAddr[1] ? MemReadData[31:16] : MemReadData[15:0];
      loadData   = MemReadData;
      misaligned = 1'b0;
      case (MemLoadType)
         LdLb:    loadData = {{24{loadByte[7]}}, loadByte};
         LdLbu:   loadData = {24'd0, loadByte};
         LdLh: begin
            loadData   = {{16{loadHalf[15]}}, loadHalf};
            misaligned = byteAddr[0];
         end
         LdLhu: begin
            loadData   = {16'd0, loadHalf};
            misaligned = byteAddr[0];
         end
         default: misaligned = (byteAddr != 2'd0);
      endcase
      // alignment only matters when the load result is actually used
      if (MemToReg != 2'd1) misaligned = 1'b0;
      case (MemToReg)
         2'd1:    nextData = loadData;
         2'd2:    nextData = MemPC + 32'd8;
         default: nextData = MemAluResult;
      endcase
      nextRegWrite = MemValid && MemRegWrite &&
                     (MemWriteRegAddr != 5'd0) && !misaligned;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite     <= 1'b0;
         WriteRegAddr <= 5'd0;
         WriteRegData <= 32'd0;
         WbValid      <= 1'b0;
         WbPC         <= RESET_PC;
         AlignErr     <= 1'b0;
         RetireCount  <= 32'd0;
      end else if (Flush) begin
         RegWrite     <= 1'b0;
         WriteRegAddr <= 5'd0;
         WriteRegData <= 32'd0;
         WbValid      <= 1'b0;
         WbPC         <= RESET_PC;
         AlignErr     <= 1'b0;
      end else if (Stall) begin
         AlignErr <= 1'b0;
      end else begin
         RegWrite     <= nextRegWrite;
         WriteRegAddr <= nextRegWrite ? MemWriteRegAddr : 5'd0;
         WriteRegData <= MemValid ? nextData : 32'd0;
         WbValid      <= MemValid;
         WbPC         <= MemValid ? MemPC : RESET_PC;
         AlignErr     <= MemValid && (MemToReg == 2'd1) && misaligned;
         if (MemValid) RetireCount <= RetireCount + 32'd1;
      end
   end

endmodule
